// File: rtl/csa_pkg.sv
// Shared constants for the sequential carry-select adder: slice width, FSM encoding,
// and the slice-index width helper.
package csa_pkg;

  localparam int unsigned SLICE_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // A single-slice build still needs a 1-bit index register.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/csa_8_bit.sv
// 8-bit carry-select adder slice: the low nibble ripples, and the high nibble is
// precomputed for both carry values and then selected.
module csa_8_bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] sum,
  output logic       c_out,
  output logic       p
);

  logic [4:0] w_lo;
  logic [4:0] w_hi0;
  logic [4:0] w_hi1;

  assign w_lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, c_in};
  assign w_hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
  assign w_hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;

  assign sum[3:0] = w_lo[3:0];
  assign sum[7:4] = w_lo[4] ? w_hi1[3:0] : w_hi0[3:0];
  assign c_out    = w_lo[4] ? w_hi1[4]   : w_hi0[4];
  assign p        = &(a ^ b);

endmodule

// File: rtl/csa_seq_adder.sv
// Multi-cycle WIDTH-bit adder that reuses one csa_8_bit slice, one byte per cycle
// LSB first, with the inter-slice carry held in a register.
module csa_seq_adder
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned SLICES = WIDTH / SLICE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned     IW       = idx_w(SLICES);
  localparam logic [IW-1:0]   LAST_IDX = IW'(SLICES - 1);

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic [IW-1:0]      r_idx;
  logic               r_carry;
  logic               r_cout;
  logic               r_ovf;

  logic [SLICE_W-1:0] w_sa;
  logic [SLICE_W-1:0] w_sb;
  logic [SLICE_W-1:0] w_ss;
  logic               w_sc;

  assign w_sa = r_a[SLICE_W*r_idx +: SLICE_W];
  assign w_sb = r_b[SLICE_W*r_idx +: SLICE_W];

  csa_8_bit u_slice (
    .a    (w_sa),
    .b    (w_sb),
    .c_in (r_carry),
    .sum  (w_ss),
    .c_out(w_sc),
    .p    ()
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= c_in;
            r_idx   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sum[SLICE_W*r_idx +: SLICE_W] <= w_ss;
          r_carry                         <= w_sc;
          if (r_idx == LAST_IDX) begin
            // Top slice's sum MSB is the final result sign.
            r_cout  <= w_sc;
            r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_ss[SLICE_W-1] != r_a[WIDTH-1]);
            r_idx   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign sum       = r_sum;
  assign c_out     = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_csa_seq_adder.sv
// Self-checking bench for csa_seq_adder (WIDTH=32) against an arithmetic reference model.
module tb_csa_seq_adder;

  localparam int unsigned W  = 32;
  localparam int unsigned NS = W / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          c_in = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  sum;
  logic          c_out;
  logic          ovf;

  int n_tests = 0;
  int n_fail  = 0;

  csa_seq_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .c_out    (c_out),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain wide addition and the sign rule.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    logic [W:0] t;
    logic       v;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return {v, t};
  endfunction

  // Drives one request from IDLE; returns edges from acceptance to out_valid (99 = timeout).
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        output int lat);
    int n;
    a = x; b = y; c_in = ci; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; c_in = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) lat = 99;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({sum, c_out, ovf, out_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: sum=%h c_out=%b ovf=%b out_valid=%b, want all 0",
               sum, c_out, ovf, out_valid);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b sum=%h, want 1 0 0",
               in_ready, out_valid, sum);
    end
  endtask

  task automatic test_vector(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic ci);
    logic [W+1:0] e;
    int           lat;
    e = model(x, y, ci);
    run_op(x, y, ci, lat);
    n_tests++;
    if (lat != NS) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d edges, want %0d", name, lat, NS);
    end
    n_tests++;
    if (sum !== e[W-1:0] || c_out !== e[W] || ovf !== e[W+1]) begin
      n_fail++;
      $display("FAIL %s_result: sum=%h c_out=%b ovf=%b, want sum=%h c_out=%b ovf=%b",
               name, sum, c_out, ovf, e[W-1:0], e[W], e[W+1]);
    end
    release_result();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b, want 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [W+1:0] e;
    logic [W-1:0] nb;
    int           lat;
    e = model(32'h0000_0001, 32'h0000_0002, 1'b0);
    run_op(32'h0000_0001, 32'h0000_0002, 1'b0, lat);
    nb = $urandom;
    a = 32'h1234_5678; b = nb; c_in = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== e[W-1:0] ||
          c_out !== e[W] || ovf !== e[W+1]) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b sum=%h, want 1 0 %h",
                 i, out_valid, in_ready, sum, e[W-1:0]);
      end
    end
    in_valid = 1'b0;
    release_result();
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_idle: in_ready=%b, want 1", in_ready);
    end
    test_vector("bp_next", 32'h1234_5678, nb, 1'b0);
  endtask

  task automatic test_reset_mid();
    a = 32'hAAAA_AAAA; b = 32'h5555_5555; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (sum[15:0] !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL mid_partial: sum=%h, want low half FFFF before reset", sum);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({sum, c_out, ovf, out_valid} !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_async_clear: sum=%h c_out=%b ovf=%b out_valid=%b in_ready=%b",
               sum, c_out, ovf, out_valid, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_vector("after_reset", 32'h0000_0001, 32'h0000_0001, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    for (int i = 0; i < 24; i++) begin
      x = $urandom;
      y = $urandom;
      if (i % 6 == 0) y = ~x;
      if (i % 6 == 1) begin x[W-1] = 1'b0; y[W-1] = 1'b0; end
      test_vector("random", x, y, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
  endtask

  initial begin
    test_reset();
    test_vector("basic",  32'h0000_00FF, 32'h0000_0001, 1'b0);
    test_vector("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    test_vector("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    test_vector("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0);
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
